// File: rtl/decoder5_32_seq_if.sv
// decoder5_32_seq_if: code/enable inputs and decoded-line outputs
// for the registered 5-to-32 decoder.
interface decoder5_32_seq_if;
  logic        EI;
  logic        GS;
  logic [4:0]  A;
  logic        scan;
  logic [31:0] Y;
  logic [4:0]  Q;
  logic        busy;
  logic        done;

  modport master (
    output EI, GS, A, scan,
    input  Y, Q, busy, done
  );

  modport slave (
    input  EI, GS, A, scan,
    output Y, Q, busy, done
  );
endinterface

// File: rtl/decoder5_32_seq.sv
// decoder5_32_seq: registered 5-to-32 line decoder with hold timer
// and auto-scan; all outputs come straight from flops.
module decoder5_32_seq #(
  parameter int HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  decoder5_32_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam logic [7:0]  CNT_LD   = 8'(HOLD - 1);
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [4:0]  r_q;
  logic [31:0] r_y;
  logic        r_busy;
  logic        r_done;

  state_t      w_state;
  logic [7:0]  w_cnt;
  logic [4:0]  w_q;
  logic [31:0] w_y;
  logic        w_done;
  logic [4:0]  w_n;
  logic [4:0]  w_q_inc;
  logic        w_req;

  assign w_n     = ~bus.A;
  assign w_q_inc = r_q + 5'd1;
  // A request only latches from IDLE or SCAN; HOLD never retriggers.
  assign w_req   = ~bus.GS && (r_state != ST_HOLD);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_q     = r_q;
    w_y     = r_y;
    w_done  = 1'b0;
    if (bus.EI) begin
      w_state = ST_IDLE;
      w_y     = ALL_ONES;
    end else if (w_req) begin
      w_state = ST_HOLD;
      w_q     = w_n;
      w_y     = ~(32'd1 << w_n);
      w_cnt   = CNT_LD;
    end else begin
      unique case (r_state)
        ST_HOLD: begin
          if (r_cnt != 8'd0) begin
            w_cnt = r_cnt - 8'd1;
          end else begin
            w_state = ST_IDLE;
            w_y     = ALL_ONES;
            w_done  = 1'b1;
          end
        end
        ST_SCAN: begin
          if (r_cnt != 8'd0) begin
            w_cnt = r_cnt - 8'd1;
          end else if (bus.scan) begin
            w_q    = w_q_inc;
            w_y    = ~(32'd1 << w_q_inc);
            w_cnt  = CNT_LD;
            w_done = (r_q == 5'd31);
          end else begin
            w_state = ST_IDLE;
            w_y     = ALL_ONES;
          end
        end
        default: begin
          if (bus.scan) begin
            w_state = ST_SCAN;
            w_q     = 5'd0;
            w_y     = 32'hFFFF_FFFE;
            w_cnt   = CNT_LD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_q     <= 5'd0;
      r_y     <= ALL_ONES;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_q     <= w_q;
      r_y     <= w_y;
      r_busy  <= (w_state != ST_IDLE);
      r_done  <= w_done;
    end
  end

  assign bus.Y    = r_y;
  assign bus.Q    = r_q;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_decoder5_32_seq.sv
// tb_decoder5_32_seq: three decoders (HOLD=4,2,3) on shared stimulus,
// each compared every cycle against a slot/remaining-cycles model.
module tb_decoder5_32_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s_ei, s_gs, s_scan;
  logic [4:0] s_a;

  decoder5_32_seq_if b0 ();
  decoder5_32_seq_if b1 ();
  decoder5_32_seq_if b2 ();

  assign b0.EI = s_ei; assign b0.GS = s_gs;
  assign b0.A = s_a;   assign b0.scan = s_scan;
  assign b1.EI = s_ei; assign b1.GS = s_gs;
  assign b1.A = s_a;   assign b1.scan = s_scan;
  assign b2.EI = s_ei; assign b2.GS = s_gs;
  assign b2.A = s_a;   assign b2.scan = s_scan;

  decoder5_32_seq #(.HOLD(4)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  decoder5_32_seq #(.HOLD(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  decoder5_32_seq #(.HOLD(3)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  localparam int M_IDLE = 0;
  localparam int M_LINE = 1;
  localparam int M_SCAN = 2;

  int hold_c [3] = '{4, 2, 3};
  int m_mode [3];
  int m_left [3];
  int m_idx  [3];
  bit m_done [3];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic get_out(input int i, output logic [31:0] y,
                         output logic [4:0] q, output logic b,
                         output logic d);
    case (i)
      0: begin y = b0.Y; q = b0.Q; b = b0.busy; d = b0.done; end
      1: begin y = b1.Y; q = b1.Q; b = b1.busy; d = b1.done; end
      default: begin y = b2.Y; q = b2.Q; b = b2.busy; d = b2.done; end
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = M_IDLE; m_left[i] = 0;
      m_idx[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  // m_left counts cycles of the current line still to come.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 1'b0;
      if (s_ei) begin
        m_mode[i] = M_IDLE;
      end else if (!s_gs && m_mode[i] != M_LINE) begin
        m_mode[i] = M_LINE;
        m_idx[i]  = 31 - int'(s_a);
        m_left[i] = hold_c[i];
      end else if (m_mode[i] == M_LINE) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_mode[i] = M_IDLE;
          m_done[i] = 1'b1;
        end
      end else if (m_mode[i] == M_SCAN) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          if (s_scan) begin
            m_idx[i]  = (m_idx[i] + 1) % 32;
            m_left[i] = hold_c[i];
            m_done[i] = (m_idx[i] == 0);
          end else begin
            m_mode[i] = M_IDLE;
          end
        end
      end else if (s_scan) begin
        m_mode[i] = M_SCAN;
        m_idx[i]  = 0;
        m_left[i] = hold_c[i];
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] y, ey;
    logic [4:0]  q;
    logic        b, d;
    for (int i = 0; i < 3; i++) begin
      get_out(i, y, q, b, d);
      ey = (m_mode[i] == M_IDLE) ? 32'hFFFF_FFFF
                                 : ~(32'd1 << m_idx[i]);
      chk($sformatf("%s.Y%0d", tag, i), y, ey);
      chk($sformatf("%s.Q%0d", tag, i), 32'(q), 32'(m_idx[i]));
      chk($sformatf("%s.busy%0d", tag, i), 32'(b),
          32'(m_mode[i] != M_IDLE));
      chk($sformatf("%s.done%0d", tag, i), 32'(d), 32'(m_done[i]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic drive(input logic ei, input logic gs,
                       input logic [4:0] a, input logic sc);
    s_ei = ei; s_gs = gs; s_a = a; s_scan = sc;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'h1F, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 1'b0;

    drive(1'b0, 1'b0, 5'b00100, 1'b0);
    tick("req27");
    chk("req27.Ylit", b0.Y, 32'hF7FF_FFFF);
    chk("req27.Qlit", 32'(b0.Q), 32'd27);
    drive(1'b0, 1'b1, 5'b00100, 1'b0);
    ticks("hold4", 3);
    chk("hold4.busy", 32'(b0.busy), 32'd1);
    tick("rel4");
    chk("rel4.done", 32'(b0.done), 32'd1);
    chk("rel4.Y", b0.Y, 32'hFFFF_FFFF);
    ticks("idle", 3);

    drive(1'b1, 1'b0, 5'b00000, 1'b0);
    ticks("eihi", 3);
    drive(1'b0, 1'b0, 5'b00000, 1'b0);
    tick("pre_rst");
    drive(1'b0, 1'b1, 5'b00000, 1'b0);
    tick("pre_rst2");
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.Ylit", b0.Y, 32'hFFFF_FFFF);
    rst = 1'b0;

    drive(1'b0, 1'b1, 5'h1F, 1'b1);
    ticks("scan", 140);

    drive(1'b1, 1'b1, 5'h1F, 1'b1);
    tick("scan_abort");
    drive(1'b0, 1'b1, 5'h1F, 1'b1);
    tick("scan_start");
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (b0.Q == 5'd5) found = 1'b1;
      else tick("scan_to5");
    end
    chk("scan_reach5", 32'(found), 32'd1);
    drive(1'b0, 1'b0, 5'b11110, 1'b1);
    tick("preempt");
    chk("preempt.Ylit", b0.Y, 32'hFFFF_FFFD);
    chk("preempt.Qlit", 32'(b0.Q), 32'd1);
    drive(1'b0, 1'b1, 5'b11110, 1'b0);
    ticks("preempt_hold", 6);

    drive(1'b0, 1'b0, 5'b00000, 1'b0);
    ticks("b2b", 16);

    drive(1'b0, 1'b0, 5'd3, 1'b0);
    tick("mid_start");
    drive(1'b0, 1'b1, 5'd7, 1'b0);
    tick("mid_a");
    drive(1'b1, 1'b1, 5'd7, 1'b0);
    tick("mid_ei");
    chk("mid_ei.Ylit", b0.Y, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 5'd5, 1'b0);
    tick("achg_start");
    drive(1'b0, 1'b0, 5'd9, 1'b0);
    tick("achg");
    chk("achg.Ylit", b0.Y, 32'hFBFF_FFFF);
    drive(1'b0, 1'b1, 5'd9, 1'b0);
    ticks("achg_rest", 5);

    for (int k = 0; k < 800; k++) begin
      drive(($urandom % 20) == 0, ($urandom % 5) != 0,
            5'($urandom), (k / 50) % 2 == 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/decoder5_32_seq.md
# decoder5_32_seq

Registered 5-to-32 line decoder with a hold timer and an auto-scan mode. It is the receiving end of the 32-input priority-encoder output: it takes the active-low 5-bit code and the active-low group-select flag and drives the corresponding single active-low output line for a programmable number of cycles. When no code is presented, it can instead walk all 32 lines in turn. This is used for line-select/indicator driving.

## Interface
- HOLD, 4, cycles each selected line is held low; legal range 1..255; 8-bit down-counter.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- EI  in  1  enable, active-low; 1 disables decoding and aborts any activity.
- GS  in  1  code valid, active-low; connects directly to the encoder GS.
- A  in  5  code, active-low; A = ~n selects line n; connects directly to the encoder Z.
- scan  in  1  1 = auto-scan lines 0..31 while no request is pending.
- Y  out  32  decoded lines, active-low, registered; at most one bit is 0.
- Q  out  5  index of the currently/last driven line, true binary, registered.
- busy  out  1  1 while in HOLD or SCAN.
- done  out  1  one-cycle pulse when a hold completes, and on each scan wrap.

## Operation
- States: IDLE, HOLD, SCAN. Reset puts the block in IDLE with Y=32'hFFFFFFFF, Q=0, busy=0, done=0, and the counter at 0.
- IDLE:
  - EI=1: stay in IDLE.
  - EI=0 and GS=0: set n=~A, Q=n, Y=~(1<<n), cnt=HOLD-1; go to HOLD.
  - Otherwise, if EI=0 and scan=1: set Q=0, Y=32'hFFFFFFFE, cnt=HOLD-1; go to SCAN.
- HOLD:
  - A and GS are ignored, so there is no retrigger.
  - When cnt≠0, cnt decrements.
  - When cnt=0: Y=all ones, done=1, go to IDLE.
- SCAN: each slot lasts HOLD cycles. At the end of a slot (cnt=0):
  - if scan=1: Q=Q+1 mod 32, Y follows Q, cnt=HOLD-1. done=1 only on the 31→0 wrap.
  - if scan=0: Y=all ones, go to IDLE, done=0.
- Request during SCAN: GS=0 with EI=0 preempts immediately. The code is latched exactly as from IDLE, the state goes to HOLD, and done=0.
- EI=1 in any state: on the next edge Y=all ones, busy=0, state IDLE, done=0. Q keeps its value.
- Priority per edge: EI abort > GS request > hold/scan timing > scan start.
- busy is registered and equals (state≠IDLE).
- Reset is honoured mid-operation with no done pulse.

## Timing
- A request sampled at edge k makes Y valid after edge k. The line stays low for exactly HOLD cycles.
- done is high in the first cycle Y returns to all ones, coincident with busy=0.
- Back-to-back: a GS=0 sampled in the done cycle re-asserts Y one cycle later. The minimum all-ones gap between holds is 1 cycle.
- HOLD=1: each hold is 1 cycle; in SCAN, Q advances every cycle.
- A full scan period is 32×HOLD cycles. done recurs every 32×HOLD cycles.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then EI=0, GS=0, A=5'b00100 for 1 cycle with HOLD=4:
  - Y=32'hF7FFFFFF, Q=27, busy=1 for exactly 4 cycles.
  - Then Y=32'hFFFFFFFF with a single done pulse.
- EI=1 with GS=0, A=5'b00000: Y stays all ones, busy=0, done=0. Then assert rst mid-HOLD: outputs return to reset values at once.
- scan=1, GS=1, HOLD=2:
  - Q steps 0,1,…,31,0 every 2 cycles; Y=~(1<<Q).
  - done pulses once, 64 cycles after the first slot.
- During SCAN at Q=5, apply GS=0, A=5'b11110 (n=1): next cycle Y=32'hFFFFFFFD, Q=1, HOLD state. After 4 cycles, done=1.
- GS=0 held continuously with A=5'b00000, HOLD=3: Y[31] low for 3 cycles, high for 1 cycle, repeating; done pulses every 4 cycles.
- Mid-HOLD EI=1: Y all ones on the next edge, no done. Then an A change during HOLD does not alter Y.
